mul_fixed_iter: RTL and testbench



---
 rtl/mul_fixed_iter.sv | 165 ++++++++++++++++
 tb/tb_mul_fixed_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_fixed_iter.sv
// Iterative signed fixed-point multiplier.
// Digit-serial accumulate, sign fix, round, saturate, valid/ready output.
module mul_fixed_iter #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 13,
  parameter int DIGIT_W = 5,
  parameter int RND_EN  = 1,
  parameter int SAT_EN  = 1
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD,
  output logic              O_RDY,
  input  logic [DATA_W-1:0] I_M1,
  input  logic [DATA_W-1:0] I_M2,
  output logic              O_VLD,
  input  logic              I_RDY,
  output logic              O_MUL_BUSY,
  output logic [DATA_W-1:0] O_PRODUCT,
  output logic              O_OVF
);

  localparam int N  = (DATA_W - 1 + DIGIT_W - 1) / DIGIT_W;
  localparam int MW = N * DIGIT_W;
  localparam int PW = 2 * DATA_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [PW:0] RC =
    (RND_EN != 0) ? ((PW+1)'(1) << (FRAC_W - 1)) : '0;

  localparam logic signed [PW:0] MAXV =
    {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]     r_m1;
  logic [PW-1:0]     r_mc;
  logic [PW-1:0]     r_acc;
  logic [MW-1:0]     r_m2;
  logic              r_msb;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_product;
  logic              r_ovf;

  logic [PW-1:0]        w_pp;
  logic [PW-1:0]        w_p;
  logic [PW:0]          w_sum;
  logic signed [PW:0]   w_r;
  logic                 w_hi;
  logic                 w_lo;
  logic [DATA_W-1:0]    w_prod;

  // Partial product of the current unsigned digit, already aligned
  assign w_pp = r_mc * PW'(r_m2[DIGIT_W-1:0]);

  // Remove the multiplier sign weight, then round at the fraction cut
  assign w_p   = r_acc - (r_msb ? (r_m1 << (DATA_W - 1)) : '0);
  assign w_sum = {w_p[PW-1], w_p} + RC;
  assign w_r   = $signed(w_sum) >>> FRAC_W;
  assign w_hi  = (w_r > MAXV);
  assign w_lo  = (w_r < MINV);

  // Clamp or wrap the rounded product to the output width
  always_comb begin
    w_prod = w_r[DATA_W-1:0];
    if (SAT_EN != 0) begin
      if (w_hi) begin
        w_prod = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (w_lo) begin
        w_prod = {1'b1, {(DATA_W-1){1'b0}}};
      end
    end
  end

  // State register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next = r_state;
    O_RDY  = 1'b0;
    O_VLD  = 1'b0;
    unique case (r_state)
      IDLE: begin
        O_RDY = 1'b1;
        if (I_VLD) w_next = CALC;
      end
      CALC: begin
        if (r_cnt == LAST) w_next = FIX;
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        O_VLD = 1'b1;
        if (I_RDY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign O_MUL_BUSY = ~O_RDY;
  assign O_PRODUCT  = r_product;
  assign O_OVF      = r_ovf;

  // Operand capture, digit accumulation and result register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_m1      <= '0;
      r_mc      <= '0;
      r_acc     <= '0;
      r_m2      <= '0;
      r_msb     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (I_VLD) begin
            r_m1  <= {{DATA_W{I_M1[DATA_W-1]}}, I_M1};
            r_mc  <= {{DATA_W{I_M1[DATA_W-1]}}, I_M1};
            r_m2  <= MW'(I_M2[DATA_W-2:0]);
            r_msb <= I_M2[DATA_W-1];
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_acc <= r_acc + w_pp;
          r_mc  <= r_mc << DIGIT_W;
          r_m2  <= r_m2 >> DIGIT_W;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_product <= w_prod;
          r_ovf     <= w_hi | w_lo;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fixed_iter.sv
// Directed bench for mul_fixed_iter: default, truncate/wrap, 24-bit builds.
// Expected values are hand-computed Q-format products or a longint model.
module tb_mul_fixed_iter;

  logic clk = 1'b0;
  logic rst_n;
  logic vld, rdy;
  logic [15:0] m1, m2;

  logic a_rdy, a_vld, a_busy, a_ovf;
  logic [15:0] a_p;
  logic b_rdy, b_vld, b_busy, b_ovf;
  logic [15:0] b_p;

  logic c_vld_i, c_rdy_i;
  logic [23:0] c_m1, c_m2;
  logic c_rdy, c_vld, c_busy, c_ovf;
  logic [23:0] c_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_fixed_iter u_a (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld), .O_RDY(a_rdy),
    .I_M1(m1), .I_M2(m2), .O_VLD(a_vld), .I_RDY(rdy),
    .O_MUL_BUSY(a_busy), .O_PRODUCT(a_p), .O_OVF(a_ovf)
  );

  mul_fixed_iter #(.RND_EN(0), .SAT_EN(0)) u_b (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld), .O_RDY(b_rdy),
    .I_M1(m1), .I_M2(m2), .O_VLD(b_vld), .I_RDY(rdy),
    .O_MUL_BUSY(b_busy), .O_PRODUCT(b_p), .O_OVF(b_ovf)
  );

  mul_fixed_iter #(.DATA_W(24), .FRAC_W(16), .DIGIT_W(4)) u_c (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(c_vld_i), .O_RDY(c_rdy),
    .I_M1(c_m1), .I_M2(c_m2), .O_VLD(c_vld), .I_RDY(c_rdy_i),
    .O_MUL_BUSY(c_busy), .O_PRODUCT(c_p), .O_OVF(c_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op16(input string tag,
                      input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] ea, input logic oa,
                      input logic [15:0] eb, input logic ob);
    int lat;
    @(negedge clk);
    m1 = x; m2 = y; vld = 1'b1; rdy = 1'b1;
    chk({tag, ".rdy"}, a_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0; m1 = ~x; m2 = ~y;
    lat = 0;
    while (a_vld !== 1'b1 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".a_p"}, a_p, ea);
    chk({tag, ".a_ovf"}, a_ovf, oa);
    chk({tag, ".b_vld"}, b_vld, 1);
    chk({tag, ".b_p"}, b_p, eb);
    chk({tag, ".b_ovf"}, b_ovf, ob);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld_fall"}, a_vld, 0);
    chk({tag, ".rdy_rise"}, a_rdy, 1);
  endtask

  task automatic op24(input string tag,
                      input logic [23:0] x, input logic [23:0] y,
                      input logic [23:0] e, input logic o);
    int lat;
    @(negedge clk);
    c_m1 = x; c_m2 = y; c_vld_i = 1'b1; c_rdy_i = 1'b1;
    chk({tag, ".rdy"}, c_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    c_vld_i = 1'b0; c_m1 = ~x; c_m2 = ~y;
    lat = 0;
    while (c_vld !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, ".lat"}, lat, 7);
    chk({tag, ".p"}, c_p, e);
    chk({tag, ".ovf"}, c_ovf, o);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld_fall"}, c_vld, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] rx, ry;
    logic [23:0] x24, y24, e24;
    logic o24;
    longint pa, pb, pp, rr;

    rst_n = 1'b0;
    vld = 1'b0; rdy = 1'b1; m1 = '0; m2 = '0;
    c_vld_i = 1'b0; c_rdy_i = 1'b1; c_m1 = '0; c_m2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.vld", a_vld, 0);
    chk("rst.rdy", a_rdy, 1);
    chk("rst.busy", a_busy, 0);
    chk("rst.p", a_p, 0);
    chk("rst.ovf", a_ovf, 0);
    chk("rst.c_rdy", c_rdy, 1);
    chk("rst.c_p", c_p, 0);
    rst_n = 1'b1;

    op16("one_one", 16'h2000, 16'h2000, 16'h2000, 0, 16'h2000, 0);
    op16("neg_one", 16'hE000, 16'h2000, 16'hE000, 0, 16'hE000, 0);
    op16("neg_neg", 16'hE000, 16'hE000, 16'h2000, 0, 16'h2000, 0);
    op16("rnd_pos", 16'h0001, 16'h1000, 16'h0001, 0, 16'h0000, 0);
    op16("rnd_neg", 16'hFFFF, 16'h1000, 16'h0000, 0, 16'hFFFF, 0);
    op16("max_max", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 16'hFFF8, 1);
    op16("min_min", 16'h8000, 16'h8000, 16'h7FFF, 1, 16'h0000, 1);
    op16("min_max", 16'h8000, 16'h7FFF, 16'h8000, 1, 16'h0004, 1);
    op16("msb_only", 16'h0800, 16'h8000, 16'hE000, 0, 16'hE000, 0);
    op16("mixed", 16'h3000, 16'hD000, 16'hB800, 0, 16'hB800, 0);

    // Backpressure: result held, extra operand pulse ignored
    @(negedge clk);
    m1 = 16'h2000; m2 = 16'hE000; vld = 1'b1; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    lat = 0;
    while (a_vld !== 1'b1 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("bp.lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp.vld", a_vld, 1);
      chk("bp.p", a_p, 16'hE000);
      chk("bp.rdy", a_rdy, 0);
      chk("bp.busy", a_busy, 1);
      if (i == 2) begin
        vld = 1'b1; m1 = 16'h7FFF; m2 = 16'h7FFF;
      end else begin
        vld = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.vld_fall", a_vld, 0);
    chk("bp.rdy_rise", a_rdy, 1);
    chk("bp.p_held", a_p, 16'hE000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp.no_queue", a_vld, 0);
    chk("bp.idle", a_rdy, 1);

    // Reset during the second CALC cycle
    @(negedge clk);
    m1 = 16'h7FFF; m2 = 16'h7FFF; vld = 1'b1; rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid.vld", a_vld, 0);
    chk("rmid.rdy", a_rdy, 1);
    chk("rmid.busy", a_busy, 0);
    chk("rmid.p", a_p, 0);
    chk("rmid.ovf", a_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rmid.no_result", a_vld, 0);
    op16("post_rst", 16'h1000, 16'h4000, 16'h2000, 0, 16'h2000, 0);

    // 24-bit Q8.16 build, digit 4, six CALC cycles
    op24("c_one", 24'h010000, 24'h010000, 24'h010000, 0);
    op24("c_min_min", 24'h800000, 24'h800000, 24'h7FFFFF, 1);
    op24("c_rnd", 24'hFFFFFF, 24'h008000, 24'h000000, 0);
    op24("c_neg", 24'hFF0000, 24'h020000, 24'hFE0000, 0);
    for (int k = 0; k < 1200; k++) begin
      rx = $urandom;
      ry = $urandom;
      x24 = rx[23:0];
      y24 = ry[23:0];
      if (k % 4 == 1) x24 = {{9{rx[31]}}, rx[14:0]};
      if (k % 4 == 2) y24 = {{9{ry[31]}}, ry[14:0]};
      pa = longint'($signed(x24));
      pb = longint'($signed(y24));
      pp = pa * pb;
      rr = (pp + 64'sd32768) >>> 16;
      o24 = (rr > 64'sd8388607) || (rr < -64'sd8388608);
      if (rr > 64'sd8388607) e24 = 24'h7FFFFF;
      else if (rr < -64'sd8388608) e24 = 24'h800000;
      else e24 = rr[23:0];
      op24("c_rand", x24, y24, e24, o24);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
